// File: rtl/mem_access_ctrl.sv
// Single-request initiator for the external single-port memory: accept, hold enables
// for WAIT_CYCLES, return a one-cycle response. Define MEMCTRL_STATS_EN for rd/wr counters.
module mem_access_ctrl #(
    parameter int MEM_WIDTH   = 32,
    parameter int MEM_SIZE    = 256,
    parameter int WAIT_CYCLES = 2
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        req_valid,
    output logic                        req_ready,
    input  logic                        req_write,
    input  logic [$clog2(MEM_SIZE)-1:0] req_addr,
    input  logic [MEM_WIDTH-1:0]        req_wdata,
    output logic                        resp_valid,
    output logic [MEM_WIDTH-1:0]        resp_rdata,
    output logic                        busy,
    output logic [$clog2(MEM_SIZE)-1:0] mem_addr,
    output logic                        mem_read_en,
    output logic                        mem_write_en,
    input  logic [MEM_WIDTH-1:0]        mem_read_val,
    output logic [MEM_WIDTH-1:0]        mem_write_val
`ifdef MEMCTRL_STATS_EN
    ,
    output logic [15:0]                 rd_count,
    output logic [15:0]                 wr_count
`endif
);

    localparam int ADDR_W   = $clog2(MEM_SIZE);
    localparam int EFF_WAIT = (WAIT_CYCLES < 1) ? 1 : WAIT_CYCLES;
    localparam int CNT_W    = (EFF_WAIT > 1) ? $clog2(EFF_WAIT) : 1;
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(EFF_WAIT - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ACCESS,
        S_RESP
    } state_t;

    state_t                 state_q, state_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic [ADDR_W-1:0]      addr_q, addr_d;
    logic [MEM_WIDTH-1:0]   wdata_q, wdata_d;
    logic                   rd_en_q, rd_en_d;
    logic                   wr_en_q, wr_en_d;
    logic                   resp_valid_q, resp_valid_d;
    logic [MEM_WIDTH-1:0]   rdata_q, rdata_d;
`ifdef MEMCTRL_STATS_EN
    logic [15:0]            rd_cnt_q, rd_cnt_d;
    logic [15:0]            wr_cnt_q, wr_cnt_d;
`endif

    always_comb begin
        // NOTE: every _d gets a default before the case so no path leaves it unassigned (no latches).
        state_d      = state_q;
        cnt_d        = cnt_q;
        addr_d       = addr_q;
        wdata_d      = wdata_q;
        rd_en_d      = rd_en_q;
        wr_en_d      = wr_en_q;
        resp_valid_d = 1'b0;
        rdata_d      = rdata_q;
`ifdef MEMCTRL_STATS_EN
        rd_cnt_d     = rd_cnt_q;
        wr_cnt_d     = wr_cnt_q;
`endif

        unique case (state_q)
            S_IDLE: begin
                if (req_valid) begin
                    addr_d  = req_addr;
                    wdata_d = req_wdata;
                    rd_en_d = !req_write;
                    wr_en_d = req_write;
                    cnt_d   = CNT_LOAD;
                    state_d = S_ACCESS;
                end
            end
            S_ACCESS: begin
                if (cnt_q == '0) begin
                    // Read data is sampled on the last enabled edge, while address is still driven.
                    if (rd_en_q) begin
                        rdata_d = mem_read_val;
                    end
`ifdef MEMCTRL_STATS_EN
                    if (rd_en_q && rd_cnt_q != 16'hFFFF) begin
                        rd_cnt_d = rd_cnt_q + 16'd1;
                    end
                    if (wr_en_q && wr_cnt_q != 16'hFFFF) begin
                        wr_cnt_d = wr_cnt_q + 16'd1;
                    end
`endif
                    rd_en_d      = 1'b0;
                    wr_en_d      = 1'b0;
                    resp_valid_d = 1'b1;
                    state_d      = S_RESP;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            S_RESP: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= S_IDLE;
            cnt_q        <= '0;
            addr_q       <= '0;
            wdata_q      <= '0;
            rd_en_q      <= 1'b0;
            wr_en_q      <= 1'b0;
            resp_valid_q <= 1'b0;
            rdata_q      <= '0;
`ifdef MEMCTRL_STATS_EN
            rd_cnt_q     <= '0;
            wr_cnt_q     <= '0;
`endif
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
            rd_en_q      <= rd_en_d;
            wr_en_q      <= wr_en_d;
            resp_valid_q <= resp_valid_d;
            rdata_q      <= rdata_d;
`ifdef MEMCTRL_STATS_EN
            rd_cnt_q     <= rd_cnt_d;
            wr_cnt_q     <= wr_cnt_d;
`endif
        end
    end

    assign req_ready     = (state_q == S_IDLE);
    assign busy          = (state_q != S_IDLE);
    assign resp_valid    = resp_valid_q;
    assign resp_rdata    = rdata_q;
    assign mem_addr      = addr_q;
    assign mem_read_en   = rd_en_q;
    assign mem_write_en  = wr_en_q;
    assign mem_write_val = wdata_q;
`ifdef MEMCTRL_STATS_EN
    assign rd_count      = rd_cnt_q;
    assign wr_count      = wr_cnt_q;
`endif

endmodule
